// File: rtl/ps2_key_event.sv
// ps2_key_event
//   Keyboard front end. Deserializes raw PS/2 frames and turns them into
//   single-cycle key events for the scancode-to-ASCII translator.
//   Handles clock-line filtering, framing and parity checking, the E0/F0
//   prefix protocol, E1 (Pause) discarding, keyboard status bytes, and
//   optional typematic-repeat suppression.
//
// Ports
//   clk        in   system clock, the only clock
//   reset      in   synchronous active-high reset
//   ps2_clk    in   raw PS/2 clock line (asynchronous)
//   ps2_data   in   raw PS/2 data line (asynchronous)
//   scancode   out  [7:0] code byte of the last event, prefixes stripped, held
//   extended   out  1 when the last event carried an E0 prefix, held
//   push_down  out  one-cycle make strobe
//   push_up    out  one-cycle break strobe
//   frame_err  out  one-cycle parity / start-stop / timeout error strobe

module ps2_key_event #(
    parameter int FILTER_LEN      = 8,
    parameter int TIMEOUT_CYCLES  = 100000,
    parameter bit SUPPRESS_REPEAT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       extended,
    output logic       push_down,
    output logic       push_up,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GOT_E0   = 3'd1,
        ST_GOT_F0   = 3'd2,
        ST_GOT_E0F0 = 3'd3,
        ST_SKIP_E1  = 3'd4
    } state_t;

    // Odd parity over 8 data bits plus the parity bit: 1 means the frame is good.
    function automatic logic odd_parity9(input logic [8:0] v);
        return ^v;
    endfunction

    // Bytes the keyboard sends on its own (BAT result, ACK, echo, resend, errors).
    function automatic logic is_status_byte(input logic [7:0] b);
        logic r;
        case (b)
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: r = 1'b1;
            default:                                  r = 1'b0;
        endcase
        return r;
    endfunction

    logic [1:0]    clk_sync_r;
    logic [1:0]    data_sync_r;
    logic          filt_clk_r;
    logic [FW-1:0] filt_cnt_r;
    logic          sample_s;

    logic [3:0]    bit_cnt_r;
    logic [8:0]    shift_r;
    logic [IW-1:0] idle_cnt_r;
    logic          byte_valid_r;
    logic          byte_err_r;
    logic [7:0]    byte_r;

    state_t        state_r;
    state_t        state_s;
    logic [2:0]    skip_cnt_r;
    logic [2:0]    skip_cnt_s;

    logic [8:0]    held_code_r;
    logic          held_valid_r;
    logic [8:0]    held_code_s;
    logic          held_valid_s;
    logic          ev_s;
    logic          brk_s;
    logic          ext_s;
    logic          match_s;
    logic          push_down_s;
    logic          push_up_s;
    logic          frame_err_s;
    logic [7:0]    scancode_s;
    logic          extended_s;

    // Two-flop synchronizers for both PS/2 lines; idle level of the bus is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_r  <= 2'b11;
            data_sync_r <= 2'b11;
        end else begin
            clk_sync_r  <= {clk_sync_r[0], ps2_clk};
            data_sync_r <= {data_sync_r[0], ps2_data};
        end
    end

    // Clock filter: the level flips only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_clk_r <= 1'b1;
            filt_cnt_r <= {FW{1'b0}};
        end else if (clk_sync_r[1] == filt_clk_r) begin
            filt_cnt_r <= {FW{1'b0}};
        end else if (filt_cnt_r == FILT_LAST) begin
            filt_clk_r <= clk_sync_r[1];
            filt_cnt_r <= {FW{1'b0}};
        end else begin
            filt_cnt_r <= filt_cnt_r + FW'(1);
        end
    end

    // Sample strobe is the cycle the filtered clock falls.
    assign sample_s = filt_clk_r & ~clk_sync_r[1] & (filt_cnt_r == FILT_LAST);

    // Frame deserializer with bit counter, parity/stop check and mid-frame timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt_r    <= 4'd0;
            shift_r      <= 9'd0;
            idle_cnt_r   <= {IW{1'b0}};
            byte_valid_r <= 1'b0;
            byte_err_r   <= 1'b0;
            byte_r       <= 8'd0;
        end else begin
            byte_valid_r <= 1'b0;
            byte_err_r   <= 1'b0;
            if (bit_cnt_r == 4'd0) begin
                idle_cnt_r <= {IW{1'b0}};
                // A high start bit is just ignored: stay waiting for a real start.
                if (sample_s && !data_sync_r[1]) begin
                    bit_cnt_r <= 4'd1;
                end
            end else if (sample_s) begin
                idle_cnt_r <= {IW{1'b0}};
                if (bit_cnt_r == 4'd10) begin
                    bit_cnt_r <= 4'd0;
                    byte_r    <= shift_r[7:0];
                    if (odd_parity9(shift_r) && data_sync_r[1]) begin
                        byte_valid_r <= 1'b1;
                    end else begin
                        byte_err_r <= 1'b1;
                    end
                end else begin
                    // Data and parity arrive LSB first; after nine shifts D0 sits in bit 0.
                    shift_r   <= {data_sync_r[1], shift_r[8:1]};
                    bit_cnt_r <= bit_cnt_r + 4'd1;
                end
            end else if (idle_cnt_r == IDLE_MAX) begin
                bit_cnt_r  <= 4'd0;
                idle_cnt_r <= {IW{1'b0}};
                byte_err_r <= 1'b1;
            end else begin
                idle_cnt_r <= idle_cnt_r + IW'(1);
            end
        end
    end

    // Byte FSM state register and Pause skip counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            skip_cnt_r <= 3'd0;
        end else begin
            state_r    <= state_s;
            skip_cnt_r <= skip_cnt_s;
        end
    end

    // Byte FSM next state: prefix tracking and E1 sequence skipping.
    always_comb begin
        state_s    = state_r;
        skip_cnt_s = skip_cnt_r;
        if (byte_err_r) begin
            state_s    = ST_IDLE;
            skip_cnt_s = 3'd0;
        end else if (byte_valid_r) begin
            if (state_r == ST_SKIP_E1) begin
                // Every byte of the Pause tail counts, including its second E1.
                skip_cnt_s = skip_cnt_r - 3'd1;
                if (skip_cnt_r == 3'd1) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_SKIP_E1;
                end
            end else if (byte_r == 8'hE1) begin
                state_s    = ST_SKIP_E1;
                skip_cnt_s = 3'd7;
            end else if ((byte_r == 8'hE0) && (state_r == ST_IDLE)) begin
                state_s = ST_GOT_E0;
            end else if ((byte_r == 8'hF0) && (state_r == ST_IDLE)) begin
                state_s = ST_GOT_F0;
            end else if ((byte_r == 8'hF0) && (state_r == ST_GOT_E0)) begin
                state_s = ST_GOT_E0F0;
            end else begin
                state_s = ST_IDLE;
            end
        end else begin
            state_s    = state_r;
            skip_cnt_s = skip_cnt_r;
        end
    end

    // Byte FSM outputs: event decode, repeat suppression and held-key tracking.
    always_comb begin
        ev_s  = 1'b0;
        brk_s = 1'b0;
        ext_s = 1'b0;
        if (byte_valid_r && (byte_r != 8'hE1)) begin
            case (state_r)
                ST_IDLE: begin
                    if ((byte_r == 8'hE0) || (byte_r == 8'hF0) || is_status_byte(byte_r)) begin
                        ev_s = 1'b0;
                    end else begin
                        ev_s = 1'b1;
                    end
                end
                ST_GOT_E0: begin
                    ext_s = 1'b1;
                    if (byte_r == 8'hF0) begin
                        ev_s = 1'b0;
                    end else begin
                        ev_s = 1'b1;
                    end
                end
                ST_GOT_F0: begin
                    ev_s  = 1'b1;
                    brk_s = 1'b1;
                end
                ST_GOT_E0F0: begin
                    ev_s  = 1'b1;
                    brk_s = 1'b1;
                    ext_s = 1'b1;
                end
                ST_SKIP_E1: ev_s = 1'b0;
                default:    ev_s = 1'b0;
            endcase
        end else begin
            ev_s = 1'b0;
        end

        match_s      = held_valid_r && (held_code_r == {ext_s, byte_r});
        push_down_s  = ev_s && !brk_s && !((SUPPRESS_REPEAT == 1'b1) && match_s);
        push_up_s    = ev_s && brk_s;
        frame_err_s  = byte_err_r;
        held_code_s  = held_code_r;
        held_valid_s = held_valid_r;
        scancode_s   = scancode;
        extended_s   = extended;

        if (ev_s) begin
            scancode_s = byte_r;
            extended_s = ext_s;
        end else begin
            scancode_s = scancode;
            extended_s = extended;
        end

        if (ev_s && !brk_s && !match_s) begin
            held_code_s  = {ext_s, byte_r};
            held_valid_s = 1'b1;
        end else if (ev_s && brk_s && (held_code_r == {ext_s, byte_r})) begin
            held_valid_s = 1'b0;
        end else begin
            held_valid_s = held_valid_r;
        end
    end

    // Registered outputs and held-key state.
    always_ff @(posedge clk) begin
        if (reset) begin
            scancode     <= 8'd0;
            extended     <= 1'b0;
            push_down    <= 1'b0;
            push_up      <= 1'b0;
            frame_err    <= 1'b0;
            held_code_r  <= 9'd0;
            held_valid_r <= 1'b0;
        end else begin
            scancode     <= scancode_s;
            extended     <= extended_s;
            push_down    <= push_down_s;
            push_up      <= push_up_s;
            frame_err    <= frame_err_s;
            held_code_r  <= held_code_s;
            held_valid_r <= held_valid_s;
        end
    end

endmodule

// File: tb/tb_ps2_key_event.sv
// tb_ps2_key_event
//   Drives PS/2 frames into two instances of ps2_key_event (repeat suppression
//   on and off) and scores every strobe against queues of expected events.

module tb_ps2_key_event;

    localparam int HALF = 20;
    localparam int TMO  = 1000;

    localparam logic [2:0] K_DOWN = 3'b100;
    localparam logic [2:0] K_UP   = 3'b010;
    localparam logic [2:0] K_ERR  = 3'b001;

    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] code;
        logic       ext;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;

    logic [7:0] sc_s, sc_n;
    logic       ex_s, ex_n, pd_s, pd_n, pu_s, pu_n, fe_s, fe_n;

    exp_t q_s[$];
    exp_t q_n[$];
    exp_t e_s;
    exp_t e_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    ps2_key_event #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO), .SUPPRESS_REPEAT(1'b1)) dut_sup (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .scancode(sc_s), .extended(ex_s), .push_down(pd_s), .push_up(pu_s), .frame_err(fe_s)
    );

    ps2_key_event #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO), .SUPPRESS_REPEAT(1'b0)) dut_rep (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .scancode(sc_n), .extended(ex_n), .push_down(pd_n), .push_up(pu_n), .frame_err(fe_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every strobe from either DUT pops and checks one expected event.
    always @(negedge clk) begin
        if (!reset) begin
            if (pd_s || pu_s || fe_s) begin
                if (q_s.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sup_unexpected: got strobes %b code %h, expected none", {pd_s, pu_s, fe_s}, sc_s);
                end else begin
                    e_s = q_s.pop_front();
                    check("sup_kind", 32'({pd_s, pu_s, fe_s}), 32'(e_s.kind));
                    if (e_s.kind != K_ERR) begin
                        check("sup_code", 32'(sc_s), 32'(e_s.code));
                        check("sup_ext", 32'(ex_s), 32'(e_s.ext));
                    end
                end
            end
            if (pd_n || pu_n || fe_n) begin
                if (q_n.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rep_unexpected: got strobes %b code %h, expected none", {pd_n, pu_n, fe_n}, sc_n);
                end else begin
                    e_n = q_n.pop_front();
                    check("rep_kind", 32'({pd_n, pu_n, fe_n}), 32'(e_n.kind));
                    if (e_n.kind != K_ERR) begin
                        check("rep_code", 32'(sc_n), 32'(e_n.code));
                        check("rep_ext", 32'(ex_n), 32'(e_n.ext));
                    end
                end
            end
        end
    end

    task automatic expect_both(input logic [2:0] k, input logic [7:0] c, input logic x);
        q_s.push_back('{kind: k, code: c, ext: x});
        q_n.push_back('{kind: k, code: c, ext: x});
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // Bit with a 3-cycle low glitch in its high phase, after the filter has settled high.
    task automatic ps2_bit_glitch(input logic b);
        ps2_data = b;
        repeat (11) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (6) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic glitch);
        logic [10:0] f;
        f = {1'b1, (~(^b)) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            if (glitch && (i == 4)) begin
                ps2_bit_glitch(f[i]);
            end else begin
                ps2_bit(f[i]);
            end
        end
        ps2_data = 1'b1;
        repeat (3 * HALF) @(negedge clk);
    endtask

    initial begin
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_scancode", 32'({sc_s, sc_n}), 32'd0);
        check("rst_extended", 32'({ex_s, ex_n}), 32'd0);
        check("rst_strobes", 32'({pd_s, pu_s, fe_s, pd_n, pu_n, fe_n}), 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // Reset in the middle of a frame: partial frame gone, no strobe.
        ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1); ps2_bit(1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (TMO + 200) @(negedge clk);

        // Plain make and break
        expect_both(K_DOWN, 8'h1C, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        expect_both(K_UP, 8'h1C, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);

        // Extended make and break
        expect_both(K_DOWN, 8'h75, 1'b1);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        expect_both(K_UP, 8'h75, 1'b1);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);

        // Typematic: suppressing instance sees one make, the other three
        q_s.push_back('{kind: K_DOWN, code: 8'h12, ext: 1'b0});
        for (int i = 0; i < 3; i++) begin
            q_n.push_back('{kind: K_DOWN, code: 8'h12, ext: 1'b0});
        end
        expect_both(K_UP, 8'h12, 1'b0);
        send_frame(8'h12, 1'b0, 1'b0);
        send_frame(8'h12, 1'b0, 1'b0);
        send_frame(8'h12, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h12, 1'b0, 1'b0);

        // Parity error then the same byte sent correctly
        expect_both(K_ERR, 8'h00, 1'b0);
        send_frame(8'h58, 1'b1, 1'b0);
        expect_both(K_DOWN, 8'h58, 1'b0);
        send_frame(8'h58, 1'b0, 1'b0);

        // Four-bit partial frame abandoned by timeout
        expect_both(K_ERR, 8'h00, 1'b0);
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
        repeat (TMO + 200) @(negedge clk);
        expect_both(K_DOWN, 8'h0E, 1'b0);
        send_frame(8'h0E, 1'b0, 1'b0);

        // Pause sequence and status bytes: silent
        send_frame(8'hE1, 1'b0, 1'b0);
        send_frame(8'h14, 1'b0, 1'b0);
        send_frame(8'h77, 1'b0, 1'b0);
        send_frame(8'hE1, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h14, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h77, 1'b0, 1'b0);
        send_frame(8'hAA, 1'b0, 1'b0);
        send_frame(8'hFA, 1'b0, 1'b0);

        // Following byte, with a short clock glitch mid-frame
        expect_both(K_DOWN, 8'h29, 1'b0);
        send_frame(8'h29, 1'b0, 1'b1);

        repeat (200) @(negedge clk);
        check("sup_queue_empty", 32'(q_s.size()), 32'd0);
        check("rep_queue_empty", 32'(q_n.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_key_event.md
# ps2_key_event

Front-end stage of the keyboard path: deserializes raw PS/2 keyboard frames and turns them into single-cycle key events (`scancode` plus `push_down`/`push_up` strobes), which drive the scancode-to-ASCII translator directly. It handles the following:
- clock-line filtering;
- frame framing and parity checking;
- the `E0`/`F0` prefix protocol;
- `E1` (Pause) sequence discarding;
- keyboard status bytes;
- optional typematic-repeat suppression, so that toggle keys (Caps Lock, language switch) fire once per physical press.

## Interface
Parameters:
- `FILTER_LEN`, 8: consecutive identical synchronized samples needed before the filtered `ps2_clk` level changes.
- `TIMEOUT_CYCLES`, 100000: idle `clk` cycles mid-frame before the partial frame is abandoned (1 ms at 100 MHz).
- `SUPPRESS_REPEAT`, 1: when 1, a repeated make code of the currently held key produces no `push_down`.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock line (asynchronous).
- `ps2_data`  in  1  raw PS/2 data line (asynchronous).
- `scancode`  out  8  last event's code byte (prefixes stripped); held between events.
- `extended`  out  1  1 if the last event carried an `E0` prefix; held with `scancode`.
- `push_down`  out  1  one-cycle strobe: key make event.
- `push_up`  out  1  one-cycle strobe: key break event.
- `frame_err`  out  1  one-cycle strobe: parity, start/stop, or timeout error.

## Operation
- **Input conditioning**
  - Both lines pass through 2-FF synchronizers.
  - `ps2_clk` is then filtered: the filtered level changes only after `FILTER_LEN` consecutive equal samples. The filtered reset level is 1.
  - A falling edge of the filtered clock is the "sample" strobe; `ps2_data` (synchronized) is captured on that cycle.
- **Frame (11 bits)**: start bit 0, 8 data bits LSB first, odd parity, stop bit 1. A bit counter runs 0..10.
  - Start bit = 1: the frame is discarded immediately and the counter stays at 0, so a wrong start bit produces no `frame_err`.
  - On bit 10, the byte is accepted iff data^parity has odd weight and stop = 1. Otherwise `frame_err` pulses and the byte is dropped.
- **Timeout**: with counter ≠ 0, the idle counter reloads on each sample strobe. When it reaches `TIMEOUT_CYCLES`, the counter returns to 0 and `frame_err` pulses.
- **Byte FSM**, states `IDLE`, `GOT_E0`, `GOT_F0`, `GOT_E0F0`, `SKIP_E1`:
  - `E0`: from `IDLE` → `GOT_E0`.
  - `F0`: from `IDLE` → `GOT_F0`; from `GOT_E0` → `GOT_E0F0`.
  - `E1`: from any state → `SKIP_E1` with skip count 7. Each accepted byte decrements the count; at 0 the FSM returns to `IDLE`. No events are emitted for the Pause sequence.
  - `AA`, `FA`, `EE`, `FE`, `00`, `FF` received in `IDLE`: ignored, no event.
  - Any other byte:
    - Event emitted: `scancode` ← byte.
    - `extended` ← (state ∈ {`GOT_E0`, `GOT_E0F0`}).
    - Break states pulse `push_up`; other states pulse `push_down`.
    - FSM returns to `IDLE`.
  - A dropped (errored) byte or a timeout returns the FSM to `IDLE` (prefixes forgotten).
- **Repeat suppression**: track `held_code` {extended, code} and `held_valid`.
  - Make event matching a valid `held_code`: no `push_down` pulse when `SUPPRESS_REPEAT` = 1. `scancode`/`extended` still update to the same values.
  - Any other make event: `held_code` ← it; `held_valid` ← 1.
  - Break event matching `held_code`: `held_valid` ← 0.
  - Break events always pulse `push_up`.
- At most one of `push_down`/`push_up` is high in any cycle. `frame_err` never coincides with an event strobe.

## Timing
- **Reset** (synchronous, 1 cycle): `scancode`=0, `extended`=0, all strobes 0, FSM `IDLE`, bit counter 0, idle counter 0, `held_valid`=0, filtered clock = 1. Reset mid-frame discards the partial frame with no strobe.
- **Latency**: let cycle N be the sample-strobe cycle of the stop bit. At cycle N+2:
  - event strobes assert;
  - `scancode`/`extended` take their new values in the same cycle as the strobe;
  - `frame_err` asserts for a bad frame.
- Every strobe is exactly 1 cycle wide.
- The strobe-to-next-strobe spacing is ≥ 1 frame. No handshake is needed, because the downstream consumer samples on every `clk`.
- Filter delay: a raw `ps2_clk` edge reaches the sample strobe after 2 + `FILTER_LEN` cycles.
- Glitch rule: a low pulse shorter than `FILTER_LEN` cycles produces no strobe.

## Test plan
- Reset, then the frame for `1C` ('A' make) → `push_down` 1 cycle, `scancode`=8'h1C, `extended`=0. Then `F0 1C` → `push_up` 1 cycle, `scancode`=8'h1C.
- `E0 75` followed by `E0 F0 75` → `push_down` with `extended`=1, `scancode`=8'h75; then `push_up` with `extended`=1. No strobes for the prefix bytes.
- Typematic: `12 12 12 F0 12` with `SUPPRESS_REPEAT`=1 → exactly one `push_down` and one `push_up`. With `SUPPRESS_REPEAT`=0 → three `push_down` pulses.
- Parity error on byte `58` (even parity sent) → one `frame_err`, no event. A following good `58` → `push_down`, `scancode`=8'h58.
- Partial frame (4 bits) then idle for `TIMEOUT_CYCLES` → one `frame_err`. The next full `0E` frame → `push_down`, `scancode`=8'h0E.
- Pause sequence `E1 14 77 E1 F0 14 F0 77`, then `AA` and `FA` → no strobes. A subsequent `29` → `push_down`, `scancode`=8'h29. A 3-cycle `ps2_clk` glitch injected mid-frame → no effect on the received byte.
